// File: rtl/soc_slave_arbiter.sv
// soc_slave_arbiter: transaction-locking arbiter that shares one memory-bus
// slave between three masters. Index 0 is high priority (external bus).
// Indices 1 and 2 are low priority (instruction, data) and are served
// round-robin between themselves. A grant is held until the transaction
// completes, aborts or times out. Every new grant is decided in an IDLE cycle.
module soc_slave_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                      clk,
    input  logic                      res,
    // master side, three buses packed side by side (master i at slice i)
    input  logic [2:0]                master_req,
    input  logic [3*ADDR_W-1:0]       master_addr,
    input  logic [3*DATA_W-1:0]       master_write_data,
    input  logic [2:0]                master_write_en,
    input  logic [3*(DATA_W/8)-1:0]   master_byte_en,
    output logic [3*DATA_W-1:0]       master_read_data,
    output logic [2:0]                master_valid,
    // shared slave
    output logic                      slave_req,
    output logic [ADDR_W-1:0]         slave_addr,
    output logic [DATA_W-1:0]         slave_write_data,
    output logic                      slave_write_en,
    output logic [DATA_W/8-1:0]       slave_byte_en,
    input  logic [DATA_W-1:0]         slave_read_data,
    input  logic                      slave_valid,
    // status
    output logic                      busy,
    output logic [1:0]                grant_index,
    output logic                      timeout_err
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int WAIT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  =
        WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic                state;
    logic [1:0]          grant_q;
    logic                rr_last;      // 1: master 2 was the last low-priority winner
    logic [STARVE_W-1:0] starve_cnt;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                low_pending;
    logic                m0_wins;
    logic [1:0]          low_pick;
    logic [1:0]          winner;

    logic                sel_req;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic [BE_W-1:0]     sel_be;

    logic                is_busy;
    logic                timeout_hit;
    logic                done;

    // Arbitration: master 0 wins unless the starvation bound forces a low-priority turn.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        low_pending = master_req[1] | master_req[2];
        m0_wins     = master_req[0] &&
                      ((STARVE_LIMIT == 0) || (starve_cnt < STARVE_MAX) || !low_pending);
        low_pick    = 2'd2;
        if (master_req[1] && master_req[2]) begin
            low_pick = rr_last ? 2'd1 : 2'd2;
        end else if (master_req[1]) begin
            low_pick = 2'd1;
        end
        winner = m0_wins ? 2'd0 : low_pick;
    end

    // Select the granted master's request fields.
    always_comb begin
        sel_req   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_be    = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant_q == 2'(i)) begin
                sel_req   = master_req[i];
                sel_addr  = master_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = master_write_data[i*DATA_W +: DATA_W];
                sel_we    = master_write_en[i];
                sel_be    = master_byte_en[i*BE_W +: BE_W];
            end
        end
    end

    assign is_busy     = (state == ST_BUSY);
    assign timeout_hit = is_busy && TIMEOUT_EN && (wait_cnt == WAIT_LAST) && !slave_valid;
    assign done        = is_busy && (slave_valid || !sel_req || timeout_hit);

    // Route the granted master to the slave, and the slave response back to it.
    always_comb begin
        slave_req        = 1'b0;
        slave_addr       = '0;
        slave_write_data = '0;
        slave_write_en   = 1'b0;
        slave_byte_en    = '0;
        master_valid     = '0;
        master_read_data = '0;
        if (is_busy) begin
            slave_req        = sel_req;
            slave_addr       = sel_addr;
            slave_write_data = sel_wdata;
            slave_write_en   = sel_we;
            slave_byte_en    = sel_be;
            for (int i = 0; i < 3; i++) begin
                if (grant_q == 2'(i)) begin
                    master_valid[i] = slave_valid | timeout_hit;
                    master_read_data[i*DATA_W +: DATA_W] =
                        timeout_hit ? '0 : slave_read_data;
                end
            end
        end
    end

    assign busy        = is_busy;
    assign grant_index = grant_q;
    assign timeout_err = timeout_hit;

    // State, grant lock, round-robin pointer, starvation and timeout counters.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (res) begin
            state      <= ST_IDLE;
            grant_q    <= 2'd0;
            rr_last    <= 1'b1;
            starve_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (|master_req) begin
                        state   <= ST_BUSY;
                        grant_q <= winner;
                        if (winner == 2'd0) begin
                            if (low_pending && (starve_cnt != STARVE_MAX)) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            starve_cnt <= '0;
                            rr_last    <= (winner == 2'd2);
                        end
                    end
                end
                default: begin
                    if (done) begin
                        state    <= ST_IDLE;
                        grant_q  <= 2'd0;
                        wait_cnt <= '0;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
